// File: rtl/exa_crosb_e2s_vc_mapper_if.sv
// ExaNet rx beat channel plus flat-VC AXIS output channel of the crossbar ingress mapper.
// The mapper takes the slave modport; the ExaNet source / s2e stage side takes master.
interface exa_crosb_e2s_vc_mapper_if #(
   parameter int prio_num = 2,
   parameter int vc_num   = 2
);
   localparam int VC_TOTAL    = prio_num * vc_num;
   localparam int LOG_VC_PRIO = (VC_TOTAL > 1) ? $clog2(VC_TOTAL) : 1;

   logic                   i_header_valid;
   logic                   o_header_ready;
   logic                   i_payload_valid;
   logic                   o_payload_ready;
   logic                   i_footer_valid;
   logic                   o_footer_ready;
   logic [127:0]           i_data;
   logic [VC_TOTAL-1:0]    i_fifo_full;
   logic                   M_AXIS_TVALID;
   logic [127:0]           M_AXIS_TDATA;
   logic                   M_AXIS_TLAST;
   logic [LOG_VC_PRIO-1:0] o_output_vc;

   modport master (
      output i_header_valid, i_payload_valid, i_footer_valid, i_data, i_fifo_full,
      input  o_header_ready, o_payload_ready, o_footer_ready,
      input  M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, o_output_vc
   );

   modport slave (
      input  i_header_valid, i_payload_valid, i_footer_valid, i_data, i_fifo_full,
      output o_header_ready, o_payload_ready, o_footer_ready,
      output M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, o_output_vc
   );
endinterface

// File: rtl/exa_crosb_e2s_vc_mapper.sv
// Crossbar ingress: decodes prio/VC from the ExaNet header, forwards beats as AXIS with a flat VC
// index, holds a packet start while its target VC is prog-full, and drops out-of-range packets.
//
//   state  | meaning
//   S_IDLE | waiting for a header; accepts it when its VC is not full (or it is out of range)
//   S_BODY | forwarding payload/footer beats of an accepted packet
//   S_DROP | consuming payload/footer beats of an out-of-range packet
module exa_crosb_e2s_vc_mapper #(
   parameter int prio_num      = 2,
   parameter int vc_num        = 2,
   parameter int PRIO_LSB      = 0,
   parameter int VC_LSB        = 8,
   parameter int MAX_PKT_BEATS = 18
) (
   input  logic                             S_ACLK,
   input  logic                             S_ARESETN,
   exa_crosb_e2s_vc_mapper_if.slave         bus,
   output logic [31:0]                      o_pkt_fwd,
   output logic [15:0]                      o_pkt_drop,
   output logic                             o_len_err
);
   localparam int VC_TOTAL    = prio_num * vc_num;
   localparam int LOG_PRIO    = (prio_num > 1) ? $clog2(prio_num) : 1;
   localparam int LOG_VC      = (vc_num > 1) ? $clog2(vc_num) : 1;
   localparam int LOG_VC_PRIO = (VC_TOTAL > 1) ? $clog2(VC_TOTAL) : 1;
   // counter is wide enough to reach MAX_PKT_BEATS+1 before it saturates
   localparam int CNT_W       = $clog2(MAX_PKT_BEATS + 2);

   typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

   state_t                 state, state_nxt;
   logic [LOG_PRIO-1:0]    hdr_prio;
   logic [LOG_VC-1:0]      hdr_vc;
   logic                   hdr_bad;
   logic [LOG_VC_PRIO-1:0] hdr_idx;
   logic                   tgt_full;

   logic hdr_rdy, pld_rdy, ftr_rdy;
   logic emit, emit_last, hdr_go, fwd_done, drop_done;

   logic                   tvalid_q, tlast_q;
   logic [127:0]           tdata_q;
   logic [LOG_VC_PRIO-1:0] vc_q;
   logic [CNT_W-1:0]       beat_cnt, cnt_inc;
   logic [31:0]            fwd_q;
   logic [15:0]            drop_q;
   logic                   len_err_q;

   assign hdr_prio = bus.i_data[PRIO_LSB +: LOG_PRIO];
   assign hdr_vc   = bus.i_data[VC_LSB +: LOG_VC];
   assign hdr_bad  = (int'(hdr_prio) >= prio_num) || (int'(hdr_vc) >= vc_num);
   assign hdr_idx  = LOG_VC_PRIO'(int'(hdr_prio) * vc_num + int'(hdr_vc));
   assign tgt_full = bus.i_fifo_full[hdr_idx];

   always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
      if (!S_ARESETN) state <= S_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      hdr_rdy   = 1'b0;
      pld_rdy   = 1'b0;
      ftr_rdy   = 1'b0;
      emit      = 1'b0;
      emit_last = 1'b0;
      hdr_go    = 1'b0;
      fwd_done  = 1'b0;
      drop_done = 1'b0;
      unique case (state)
         S_IDLE: begin
            hdr_rdy = hdr_bad | ~tgt_full;
            if (bus.i_header_valid && hdr_rdy) begin
               if (hdr_bad) begin
                  state_nxt = S_DROP;
               end else begin
                  state_nxt = S_BODY;
                  emit      = 1'b1;
                  hdr_go    = 1'b1;
               end
            end
         end
         S_BODY: begin
            // footer wins a tie so the packet closes with exactly one last beat
            ftr_rdy = 1'b1;
            pld_rdy = ~bus.i_footer_valid;
            if (bus.i_footer_valid) begin
               emit      = 1'b1;
               emit_last = 1'b1;
               fwd_done  = 1'b1;
               state_nxt = S_IDLE;
            end else if (bus.i_payload_valid) begin
               emit = 1'b1;
            end
         end
         S_DROP: begin
            ftr_rdy = 1'b1;
            pld_rdy = 1'b1;
            if (bus.i_footer_valid) begin
               drop_done = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign cnt_inc = (beat_cnt == {CNT_W{1'b1}}) ? beat_cnt : beat_cnt + CNT_W'(1);

   always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
      if (!S_ARESETN) begin
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         tdata_q   <= '0;
         vc_q      <= '0;
         beat_cnt  <= '0;
         fwd_q     <= '0;
         drop_q    <= '0;
         len_err_q <= 1'b0;
      end else begin
         tvalid_q <= emit;
         if (emit) begin
            tdata_q <= bus.i_data;
            tlast_q <= emit_last;
         end
         if (hdr_go) begin
            vc_q     <= hdr_idx;
            beat_cnt <= CNT_W'(1);
         end else if (emit) begin
            beat_cnt <= cnt_inc;
            if (int'(cnt_inc) > MAX_PKT_BEATS) len_err_q <= 1'b1;
         end
         if (fwd_done) fwd_q <= fwd_q + 32'd1;
         if (drop_done && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
   end

   assign bus.o_header_ready  = hdr_rdy;
   assign bus.o_payload_ready = pld_rdy;
   assign bus.o_footer_ready  = ftr_rdy;
   assign bus.M_AXIS_TVALID   = tvalid_q;
   assign bus.M_AXIS_TDATA    = tdata_q;
   assign bus.M_AXIS_TLAST    = tlast_q;
   assign bus.o_output_vc     = vc_q;
   assign o_pkt_fwd           = fwd_q;
   assign o_pkt_drop          = drop_q;
   assign o_len_err           = len_err_q;
endmodule

// File: tb/tb_exa_crosb_e2s_vc_mapper.sv
// Bench for the ingress VC mapper: directed packets then random packets against a queue-based
// model of expected AXIS beats (due cycle, data, last, flat VC) and packet counters.
module tb_exa_crosb_e2s_vc_mapper;
   localparam int PRIO_NUM = 3;   // three priorities so a 2-bit prio field can be out of range
   localparam int VC_NUM   = 2;
   localparam int MAXB     = 18;
   localparam int NVC      = PRIO_NUM * VC_NUM;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   exa_crosb_e2s_vc_mapper_if #(.prio_num(PRIO_NUM), .vc_num(VC_NUM)) bus ();
   logic [31:0] pkt_fwd;
   logic [15:0] pkt_drop;
   logic        len_err;

   exa_crosb_e2s_vc_mapper #(
      .prio_num(PRIO_NUM), .vc_num(VC_NUM), .PRIO_LSB(0), .VC_LSB(8), .MAX_PKT_BEATS(MAXB)
   ) dut (
      .S_ACLK(clk), .S_ARESETN(rst_n), .bus(bus),
      .o_pkt_fwd(pkt_fwd), .o_pkt_drop(pkt_drop), .o_len_err(len_err)
   );

   typedef struct {
      longint       due;
      logic [127:0] data;
      logic         last;
      logic [2:0]   vc;
   } beat_t;

   beat_t  exp_q[$];
   longint cyc = 0;
   int     n_chk = 0;
   int     n_fail = 0;
   int     exp_fwd = 0;
   int     exp_drop = 0;
   bit     exp_err = 1'b0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // every cycle: either the next expected beat is due now, or TVALID must be low
   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            beat_t e;
            e = exp_q.pop_front();
            chk("tvalid", bus.M_AXIS_TVALID, 1);
            chk("tdata", bus.M_AXIS_TDATA, e.data);
            chk("tlast", bus.M_AXIS_TLAST, e.last);
            chk("out_vc", bus.o_output_vc, e.vc);
         end else begin
            chk("tvalid_idle", bus.M_AXIS_TVALID, 0);
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
               chk("beat_missed", 0, 1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // kind: 0 header, 1 payload, 2 footer. Called and returns just after a rising edge.
   task automatic drive_beat(input int kind, input logic [127:0] d, input bit good,
                             input logic [2:0] vc, input int hold);
      logic rdy;
      bus.i_data          = d;
      bus.i_header_valid  = (kind == 0);
      bus.i_payload_valid = (kind == 1);
      bus.i_footer_valid  = (kind == 2);
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (kind == 0) begin
            chk("hdr_rdy", bus.o_header_ready, (!good || !bus.i_fifo_full[vc]) ? 1 : 0);
            chk("pld_rdy_idle", bus.o_payload_ready, 0);
            rdy = bus.o_header_ready;
         end else if (kind == 1) begin
            chk("pld_rdy", bus.o_payload_ready, 1);
            rdy = bus.o_payload_ready;
         end else begin
            chk("ftr_rdy", bus.o_footer_ready, 1);
            rdy = bus.o_footer_ready;
         end
         if (rdy) begin
            if (good) exp_q.push_back('{cyc + 1, d, (kind == 2), vc});
            @(posedge clk); #1;
            bus.i_header_valid  = 1'b0;
            bus.i_payload_valid = 1'b0;
            bus.i_footer_valid  = 1'b0;
            return;
         end
         @(posedge clk); #1;
         if (kind == 0 && good && t + 1 >= hold) bus.i_fifo_full[vc] = 1'b0;
      end
      chk("ready_timeout", 0, 1);
      bus.i_header_valid  = 1'b0;
      bus.i_payload_valid = 1'b0;
      bus.i_footer_valid  = 1'b0;
   endtask

   task automatic send_pkt(input int p, input int v, input int npay, input int hold, input int gap);
      logic [127:0] d;
      logic [2:0]   vc;
      bit           good;
      logic [NVC-1:0] full;
      good = (p < PRIO_NUM);
      vc   = 3'(p * VC_NUM + v);
      d    = rnd128();
      d[1:0] = 2'(p);
      d[8]   = 1'(v);
      full = NVC'($urandom);
      if (good) full[vc] = (hold > 0);
      bus.i_fifo_full = full;
      drive_beat(0, d, good, vc, hold);
      for (int i = 0; i < npay; i++) begin
         bus.i_fifo_full = NVC'($urandom);
         repeat ($urandom_range(0, gap)) @(posedge clk);
         #1;
         drive_beat(1, rnd128(), good, vc, 0);
      end
      repeat ($urandom_range(0, gap)) @(posedge clk);
      #1;
      drive_beat(2, rnd128(), good, vc, 0);
      if (good) begin
         exp_fwd++;
         if (npay + 2 > MAXB) exp_err = 1'b1;
      end else if (exp_drop < 65535) begin
         exp_drop++;
      end
      chk("pkt_fwd", pkt_fwd, exp_fwd);
      chk("pkt_drop", pkt_drop, exp_drop);
      chk("len_err", len_err, exp_err);
   endtask

   initial begin
      logic [127:0] d;
      bus.i_header_valid  = 1'b0;
      bus.i_payload_valid = 1'b0;
      bus.i_footer_valid  = 1'b0;
      bus.i_data          = '0;
      bus.i_fifo_full     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", bus.M_AXIS_TVALID, 0);
      chk("rst_tdata", bus.M_AXIS_TDATA, 0);
      chk("rst_tlast", bus.M_AXIS_TLAST, 0);
      chk("rst_vc", bus.o_output_vc, 0);
      chk("rst_fwd", pkt_fwd, 0);
      chk("rst_drop", pkt_drop, 0);
      chk("rst_len_err", len_err, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      send_pkt(1, 0, 3, 0, 0);          // 5 beats, vc 2
      send_pkt(1, 1, 1, 10, 0);         // vc 3 held by prog-full for 10 cycles
      send_pkt(3, 0, 2, 0, 0);          // out-of-range prio, dropped
      send_pkt(0, 0, 0, 0, 0);          // back-to-back header+footer packets
      send_pkt(0, 1, 0, 0, 0);

      // payload and footer offered together: footer taken, payload held off
      bus.i_fifo_full = '0;
      d = rnd128(); d[1:0] = 2'd2; d[8] = 1'b1;
      drive_beat(0, d, 1'b1, 3'd5, 0);
      d = rnd128();
      bus.i_data          = d;
      bus.i_payload_valid = 1'b1;
      bus.i_footer_valid  = 1'b1;
      @(negedge clk);
      chk("tie_pld_rdy", bus.o_payload_ready, 0);
      chk("tie_ftr_rdy", bus.o_footer_ready, 1);
      exp_q.push_back('{cyc + 1, d, 1'b1, 3'd5});
      @(posedge clk); #1;
      bus.i_payload_valid = 1'b0;
      bus.i_footer_valid  = 1'b0;
      exp_fwd++;
      chk("tie_fwd", pkt_fwd, exp_fwd);

      send_pkt(2, 0, MAXB - 2, 0, 0);   // exactly MAXB beats: no length error
      send_pkt(0, 1, MAXB - 1, 0, 1);   // MAXB+1 beats: sticky length error
      send_pkt(1, 0, 1, 0, 0);

      for (int i = 0; i < 40; i++)
         send_pkt($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 5),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0, 2);

      // reset in the middle of a packet
      bus.i_fifo_full = '0;
      d = rnd128(); d[1:0] = 2'd0; d[8] = 1'b1;
      drive_beat(0, d, 1'b1, 3'd1, 0);
      drive_beat(1, rnd128(), 1'b1, 3'd1, 0);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      exp_fwd  = 0;
      exp_drop = 0;
      exp_err  = 1'b0;
      #1;
      chk("mid_rst_tvalid", bus.M_AXIS_TVALID, 0);
      chk("mid_rst_fwd", pkt_fwd, 0);
      chk("mid_rst_drop", pkt_drop, 0);
      chk("mid_rst_len_err", len_err, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_pkt(2, 1, 2, 0, 0);
      send_pkt(3, 1, 1, 0, 0);

      repeat (4) @(posedge clk);
      #1;
      chk("drain", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
